// File: rtl/config_frame_sequencer_pkg.sv
// Shared fabric configuration definitions: sequencer state encoding and the
// default synchronisation word.
package config_frame_sequencer_pkg;

  localparam logic [1:0] ST_DESYNC = 2'd0;
  localparam logic [1:0] ST_ADDR   = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

endpackage

// File: rtl/config_frame_sequencer.sv
// Configuration frame sequencer: syncs on a magic word, then loads one frame
// address plus one data word per row and pulses LongFrameStrobe to commit.
module config_frame_sequencer
  import config_frame_sequencer_pkg::*;
#(
  parameter int NumberOfRows    = 8,
  parameter int RowSelectWidth  = 5,
  parameter int FrameBitsPerRow = 32,
  parameter int desync_flag     = 20,
  parameter logic [FrameBitsPerRow-1:0] SyncWord = FrameBitsPerRow'(SYNC_WORD_DEFAULT)
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] WriteData,
  input  logic                       WriteStrobe,
  output logic [FrameBitsPerRow-1:0] ConfigWriteData,
  output logic [RowSelectWidth-1:0]  RowSelect,
  output logic [FrameBitsPerRow-1:0] FrameAddressRegister,
  output logic                       LongFrameStrobe,
  output logic                       ConfigActive
);

  localparam logic [RowSelectWidth-1:0] LAST_ROW = RowSelectWidth'(NumberOfRows);
  localparam logic [RowSelectWidth-1:0] FIRST_ROW = RowSelectWidth'(1);

  logic [1:0]                 r_state;
  logic [RowSelectWidth-1:0]  r_row_cnt;
  logic [FrameBitsPerRow-1:0] r_pend_word;
  logic                       r_pend_vld;
  logic [FrameBitsPerRow-1:0] r_cfg_data;
  logic [FrameBitsPerRow-1:0] r_frame_addr;
  logic [RowSelectWidth-1:0]  r_row_sel;
  logic                       r_long_strobe;

  logic                       w_in_commit;
  logic                       w_word_vld;
  logic [FrameBitsPerRow-1:0] w_word;

  // A held word always goes first; the live strobe then takes its place.
  assign w_in_commit = (r_state == ST_COMMIT);
  assign w_word_vld  = !w_in_commit && (r_pend_vld || WriteStrobe);
  assign w_word      = r_pend_vld ? r_pend_word : WriteData;

  // NOTE: non-blocking assignments so every register sees pre-edge values,
  // and the pending word is cleared on reset because it is live control state.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_DESYNC;
      r_row_cnt     <= '0;
      r_pend_word   <= '0;
      r_pend_vld    <= 1'b0;
      r_cfg_data    <= '0;
      r_frame_addr  <= '0;
      r_row_sel     <= '0;
      r_long_strobe <= 1'b0;
    end else begin
      r_row_sel     <= '0;
      r_long_strobe <= 1'b0;

      if (w_in_commit) begin
        if (WriteStrobe && !r_pend_vld) begin
          r_pend_word <= WriteData;
          r_pend_vld  <= 1'b1;
        end
      end else if (r_pend_vld) begin
        r_pend_vld  <= WriteStrobe;
        r_pend_word <= WriteStrobe ? WriteData : '0;
      end

      case (r_state)
        ST_DESYNC: begin
          if (w_word_vld && (w_word == SyncWord)) r_state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (w_word_vld) begin
            if (w_word[desync_flag]) begin
              r_state <= ST_DESYNC;
            end else begin
              r_frame_addr <= w_word;
              r_row_cnt    <= FIRST_ROW;
              r_state      <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // Data words are loaded verbatim, never decoded as sync/desync.
          if (w_word_vld) begin
            r_cfg_data <= w_word;
            r_row_sel  <= r_row_cnt;
            if (r_row_cnt == LAST_ROW) begin
              r_row_cnt <= '0;
              r_state   <= ST_COMMIT;
            end else begin
              r_row_cnt <= r_row_cnt + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          r_long_strobe <= 1'b1;
          r_state       <= ST_ADDR;
        end
        default: r_state <= ST_DESYNC;
      endcase
    end
  end

  assign ConfigWriteData      = r_cfg_data;
  assign RowSelect            = r_row_sel;
  assign FrameAddressRegister = r_frame_addr;
  assign LongFrameStrobe      = r_long_strobe;
  assign ConfigActive         = (r_state != ST_DESYNC);

endmodule

// File: tb/tb_config_frame_sequencer.sv
// Directed bench for config_frame_sequencer: row writes are scoreboarded,
// frame commits and state changes are checked at fixed points.
module tb_config_frame_sequencer;

  logic        CLK;
  logic        resetn;
  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic [31:0] ConfigWriteData;
  logic [4:0]  RowSelect;
  logic [31:0] FrameAddressRegister;
  logic        LongFrameStrobe;
  logic        ConfigActive;

  typedef struct {
    logic [4:0]  row;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];
  int  total   = 0;
  int  bad     = 0;
  int  lfs_cnt = 0;
  int  exp_lfs = 0;

  config_frame_sequencer dut (
    .CLK                 (CLK),
    .resetn              (resetn),
    .WriteData           (WriteData),
    .WriteStrobe         (WriteStrobe),
    .ConfigWriteData     (ConfigWriteData),
    .RowSelect           (RowSelect),
    .FrameAddressRegister(FrameAddressRegister),
    .LongFrameStrobe     (LongFrameStrobe),
    .ConfigActive        (ConfigActive)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One strobe cycle; returns 1 time unit into the following cycle.
  task automatic send(input logic [31:0] word);
    WriteData   = word;
    WriteStrobe = 1'b1;
    @(posedge CLK);
    #1;
    WriteStrobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push_row(input int row, input logic [31:0] data);
    sb_t e;
    e.row  = 5'(row);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_lfs(input string tag, input int max_cycles);
    int n = 0;
    while (!LongFrameStrobe && n < max_cycles) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check(tag, 32'(LongFrameStrobe), 1);
  endtask

  // Row writes are checked against the scoreboard whenever RowSelect is non-zero.
  always @(negedge CLK) begin
    if (resetn) begin
      if (RowSelect != 5'd0) begin
        if (sb.size() == 0) begin
          check("row_unexpected", 32'(RowSelect), 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("row_sel", 32'(RowSelect), 32'(e.row));
          check("row_data", ConfigWriteData, e.data);
        end
      end
      if (LongFrameStrobe) lfs_cnt++;
    end
  end

  initial begin
    logic [31:0] words [8];
    resetn      = 1'b0;
    WriteData   = '0;
    WriteStrobe = 1'b0;

    // Reset state
    idle(2);
    check("rst_active", 32'(ConfigActive), 0);
    check("rst_rowsel", 32'(RowSelect), 0);
    check("rst_far", FrameAddressRegister, 0);
    check("rst_cwd", ConfigWriteData, 0);
    check("rst_lfs", 32'(LongFrameStrobe), 0);
    resetn = 1'b1;
    idle(1);
    send(32'h1234_5678);
    check("desync_discard", 32'(ConfigActive), 0);

    // Sync
    send(32'hFAB0_FAB1);
    check("sync_active", 32'(ConfigActive), 1);
    check("sync_rowsel", 32'(RowSelect), 0);
    check("sync_lfs", 32'(LongFrameStrobe), 0);

    // Single frame, rows 1..8 on consecutive cycles
    send(32'h0800_0001);
    check("f1_far", FrameAddressRegister, 32'h0800_0001);
    for (int i = 1; i <= 8; i++) begin
      push_row(i, 32'(i * 'h11));
      send(32'(i * 'h11));
      check("f1_row_now", 32'(RowSelect), 32'(i));
      check("f1_data_now", ConfigWriteData, 32'(i * 'h11));
    end
    check("f1_lfs_early", 32'(LongFrameStrobe), 0);
    idle(1);
    check("f1_lfs", 32'(LongFrameStrobe), 1);
    exp_lfs++;
    check("f1_far_commit", FrameAddressRegister, 32'h0800_0001);
    idle(1);
    check("f1_lfs_one", 32'(LongFrameStrobe), 0);
    check("f1_rows_done", 32'(sb.size()), 0);

    // Back-to-back frames: next address arrives during COMMIT
    send(32'h0800_0001);
    for (int i = 1; i <= 8; i++) begin
      push_row(i, 32'(i * 'h11));
      send(32'(i * 'h11));
    end
    send(32'h1000_0002);
    check("b2b_lfs", 32'(LongFrameStrobe), 1);
    exp_lfs++;
    check("b2b_far_hold", FrameAddressRegister, 32'h0800_0001);
    for (int i = 1; i <= 8; i++) begin
      words[i-1] = 32'hA000_0000 | 32'(i);
      push_row(i, words[i-1]);
    end
    send(words[0]);
    check("b2b_far_new", FrameAddressRegister, 32'h1000_0002);
    check("b2b_lfs_off", 32'(LongFrameStrobe), 0);
    for (int i = 1; i < 8; i++) send(words[i]);
    wait_lfs("b2b_f2_lfs", 10);
    exp_lfs++;
    check("b2b_f2_far", FrameAddressRegister, 32'h1000_0002);
    check("b2b_rows_done", 32'(sb.size()), 0);
    idle(1);

    // Desync through address bit 20
    send(32'h0010_0000);
    check("ds_active", 32'(ConfigActive), 0);
    check("ds_far", FrameAddressRegister, 32'h1000_0002);
    for (int i = 0; i < 3; i++) begin
      send(32'h0000_0055);
      check("ds_rowsel", 32'(RowSelect), 0);
    end
    check("ds_still_off", 32'(ConfigActive), 0);

    // Sync and desync patterns inside a frame are plain row data
    send(32'hFAB0_FAB1);
    send(32'h2000_0003);
    for (int i = 1; i <= 8; i++) begin
      words[i-1] = (i == 3) ? 32'hFAB0_FAB1 : (i == 5) ? 32'h0010_0000 : 32'h0000_0100 + 32'(i);
      push_row(i, words[i-1]);
      send(words[i-1]);
      check("emb_active", 32'(ConfigActive), 1);
    end
    idle(1);
    check("emb_lfs", 32'(LongFrameStrobe), 1);
    exp_lfs++;
    check("emb_far", FrameAddressRegister, 32'h2000_0003);
    check("emb_rows_done", 32'(sb.size()), 0);

    // Reset mid-frame after the 4th data word
    send(32'h3000_0004);
    for (int i = 1; i <= 4; i++) begin
      push_row(i, 32'h0000_0C00 + 32'(i));
      send(32'h0000_0C00 + 32'(i));
    end
    @(negedge CLK);
    #2;
    resetn = 1'b0;
    #1;
    check("mr_active", 32'(ConfigActive), 0);
    check("mr_rowsel", 32'(RowSelect), 0);
    check("mr_far", FrameAddressRegister, 0);
    check("mr_cwd", ConfigWriteData, 0);
    check("mr_lfs", 32'(LongFrameStrobe), 0);
    idle(2);
    resetn = 1'b1;
    send(32'h0000_0C05);
    check("mr_5th_rowsel", 32'(RowSelect), 0);
    check("mr_5th_active", 32'(ConfigActive), 0);
    idle(4);
    check("mr_no_lfs", 32'(LongFrameStrobe), 0);

    check("lfs_total", 32'(lfs_cnt), 32'(exp_lfs));
    check("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
